daf_sequencer: RTL and testbench
================================

# daf_sequencer

Frame-level controller for the digital audio effects (DAF) chain. Once per incoming 32-bit sample it starts the enabled effect stages in fixed order: flanger, amp clip, amp comp, fader. It waits for each stage's done handshake, then commits the result. It also owns the flanger delay-memory write pointer and executes the mem_clr / mem_init / mem_dump commands.

## Interface
Parameters:
- ADDR_W, 10, delay-memory address width; depth = 2^ADDR_W words.

Ports:
- tb_clk  in  1  system clock; one clock, all logic on rising edge.
- tb_n_rst  in  1  reset, synchronous, active-low.
- sample_valid  in  1  one-cycle pulse: new input sample latched upstream.
- swch_mode_en  in  4  stage enables: [0] flanger, [1] amp clip, [2] amp comp, [3] fader.
- stage_done  in  4  one-cycle completion pulse per stage, same bit order.
- mem_clr  in  1  pulse: zero the whole delay memory.
- mem_init  in  1  pulse: reset write pointer, keep memory contents.
- mem_dump  in  1  pulse: read out the whole delay memory.
- stage_go  out  4  one-hot start pulse to a stage.
- out_load  out  1  pulse: output register captures the chain result.
- mem_addr  out  ADDR_W  delay-memory address.
- mem_we  out  1  delay-memory write enable.
- mem_wzero  out  1  write data forced to 0 (clear).
- mem_re  out  1  delay-memory read enable (dump).
- wr_ptr  out  ADDR_W  current circular write pointer (flanger taps derive read address).
- busy  out  1  state != IDLE.
- overrun  out  1  sticky: sample_valid arrived while busy.

## Operation
- States: IDLE, SCAN, WAIT, COMMIT, CLEAR, DUMP. Registers: idx (2 bit), mode_q (4 bit), cnt (ADDR_W), wr_ptr, overrun.
- IDLE priority: mem_clr > mem_dump > mem_init > sample_valid.
  - mem_clr: cnt<=0, go to CLEAR.
  - mem_dump: cnt<=0, go to DUMP.
  - mem_init: wr_ptr<=0, stay in IDLE.
  - sample_valid: mode_q<=swch_mode_en, idx<=0, go to SCAN.
- SCAN:
  - If mode_q[idx]=1: stage_go[idx]=1 this cycle, go to WAIT.
  - Otherwise the stage is bypassed: idx++; if idx was 3, go to COMMIT.
  - Each bypassed stage costs exactly one cycle.
- WAIT:
  - On stage_done[idx]: if idx==3 go to COMMIT, else idx++ and go to SCAN.
  - Other stage_done bits are ignored.
  - A done pulse in the same cycle as stage_go is ignored.
- COMMIT (one cycle): out_load=1, mem_we=1, mem_addr=wr_ptr, then wr_ptr++ (wraps 2^ADDR_W-1 -> 0), go to IDLE.
  - The write occurs even when the flanger is disabled, so the delay line stays continuous.
- CLEAR:
  - mem_we=1, mem_wzero=1, mem_addr=cnt, cnt++.
  - At cnt=2^ADDR_W-1: wr_ptr<=0, overrun<=0, go to IDLE.
- DUMP: mem_re=1, mem_addr=cnt, cnt++; at the last address go to IDLE. wr_ptr is unchanged.
- mem_addr equals wr_ptr in IDLE, SCAN and WAIT.
- Boundaries:
  - sample_valid outside IDLE: the sample is dropped and overrun<=1.
  - mem_clr in SCAN or WAIT: the frame aborts with no out_load, then CLEAR.
  - mem_clr in DUMP or CLEAR: ignored.
  - mem_dump and mem_init outside IDLE: ignored.
  - swch_mode_en changes mid-frame: no effect (mode_q is used).
- Reset: state IDLE, idx 0, cnt 0, wr_ptr 0, overrun 0, mode_q 0.
  - All outputs are 0, except busy=0 and mem_addr=0.
  - Reset mid-frame, mid-clear or mid-dump aborts immediately, with no further pulses.

## Timing
- Outputs are decoded from registered state only.
- Sample_valid is sampled in cycle T. The sequence is then:
  - T+1: SCAN idx0.
  - Disabled stage: 1 cycle.
  - Enabled stage: 1 cycle (SCAN) plus the cycles until stage_done, counted from the cycle after go.
  - COMMIT last.
- All stages disabled: out_load at T+5.
- All enabled, each done one cycle after go: out_load at T+9.
- Frame budget is 31 cycles per sample. Exceeding it shows up as overrun.
- CLEAR and DUMP take 2^ADDR_W cycles each; busy falls on the cycle after the last address.

## Structure
- daf_pkg:
  - state enum.
  - Stage index constants STG_FLANGER=0, STG_AMPCLP=1, STG_AMPCOM=2, STG_FADER=3.
  - FRAME_CYCLES=31.
- Sub-module daf_addr_ctr: parameterised ADDR_W wrap counter with clear and increment. It is instantiated twice, once for wr_ptr and once for cnt.

## Test plan
- Reset, then mode 4'b0000 and sample_valid: no stage_go, out_load at T+5, wr_ptr 0->1.
- Mode 4'b1111, each done 1 cycle after go: stage_go 0001,0010,0100,1000 in order; out_load at T+9; mem_we with mem_addr=0.
- Mode 4'b0101, done never returns for stage 0: busy stays high; a second sample_valid sets overrun; mem_clr aborts, with no out_load.
- ADDR_W=4, 16 samples: wr_ptr wraps 15->0; mem_init mid-run forces wr_ptr=0.
- mem_clr and mem_dump in the same IDLE cycle: CLEAR wins; 16 writes with mem_wzero, addr 0..15; overrun cleared; then mem_dump gives 16 mem_re cycles.
- tb_n_rst low for one cycle mid-WAIT: next cycle state IDLE, all outputs 0, wr_ptr 0.

Source files
------------

// File: rtl/daf_pkg.sv
// daf_pkg: sequencer state encoding, stage index constants and frame budget
package daf_pkg;
  typedef enum logic [2:0] {IDLE, SCAN, WAIT, COMMIT, CLEAR, DUMP} state_t;
  localparam int STG_FLANGER  = 0;
  localparam int STG_AMPCLP   = 1;
  localparam int STG_AMPCOM   = 2;
  localparam int STG_FADER    = 3;
  localparam int FRAME_CYCLES = 31;
endpackage

// File: rtl/daf_addr_ctr.sv
// daf_addr_ctr: ADDR_W wrap counter (clk_i, n_rst_i, clr_i beats inc_i; cnt_o)
module daf_addr_ctr #(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              n_rst_i,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] cnt_o
);
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : inc_i ? cnt_q + ADDR_W'(1) : cnt_q;
  always_ff @(posedge clk_i) cnt_q <= !n_rst_i ? '0 : cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/daf_sequencer.sv
// daf_sequencer: per-sample DAF stage sequencer and delay-memory controller (in: clock, n_rst, sample/mode/done/mem cmds; out: stage_go, out_load, mem_*, wr_ptr, busy, overrun)
module daf_sequencer
  import daf_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              tb_clk,
  input  logic              tb_n_rst,
  input  logic              sample_valid,
  input  logic [3:0]        swch_mode_en,
  input  logic [3:0]        stage_done,
  input  logic              mem_clr,
  input  logic              mem_init,
  input  logic              mem_dump,
  output logic [3:0]        stage_go,
  output logic              out_load,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_wzero,
  output logic              mem_re,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              busy,
  output logic              overrun
);
  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        mode_q, mode_d;
  logic              overrun_q, overrun_d;
  logic              wp_clr, wp_inc, cnt_clr, cnt_inc, cnt_last;
  logic [ADDR_W-1:0] cnt;
  daf_addr_ctr #(.ADDR_W(ADDR_W)) u_wp (
    .clk_i(tb_clk), .n_rst_i(tb_n_rst), .clr_i(wp_clr), .inc_i(wp_inc), .cnt_o(wr_ptr)
  );
  daf_addr_ctr #(.ADDR_W(ADDR_W)) u_cnt (
    .clk_i(tb_clk), .n_rst_i(tb_n_rst), .clr_i(cnt_clr), .inc_i(cnt_inc), .cnt_o(cnt)
  );
  assign cnt_last  = &cnt;
  assign stage_go  = (state_q == SCAN && mode_q[idx_q]) ? 4'(1 << idx_q) : 4'b0;
  assign out_load  = state_q == COMMIT;
  assign mem_we    = state_q == COMMIT || state_q == CLEAR;
  assign mem_wzero = state_q == CLEAR;
  assign mem_re    = state_q == DUMP;
  assign mem_addr  = (state_q == CLEAR || state_q == DUMP) ? cnt : wr_ptr;
  assign busy      = state_q != IDLE;
  assign overrun   = overrun_q;
  assign wp_inc    = state_q == COMMIT;
  assign cnt_inc   = state_q == CLEAR || state_q == DUMP;
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mode_d    = mode_q;
    overrun_d = overrun_q | (sample_valid & busy);
    wp_clr    = 1'b0;
    cnt_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_clr) begin
          cnt_clr = 1'b1;
          state_d = CLEAR;
        end else if (mem_dump) begin
          cnt_clr = 1'b1;
          state_d = DUMP;
        end else if (mem_init) begin
          wp_clr = 1'b1;
        end else if (sample_valid) begin
          mode_d  = swch_mode_en;
          idx_d   = 2'(STG_FLANGER);
          state_d = SCAN;
        end
      end
      SCAN: begin
        idx_d   = mode_q[idx_q] ? idx_q : idx_q + 2'd1;
        state_d = mode_q[idx_q] ? WAIT : (idx_q == 2'(STG_FADER)) ? COMMIT : SCAN;
      end
      WAIT: if (stage_done[idx_q]) begin
        idx_d   = idx_q + 2'd1;
        state_d = (idx_q == 2'(STG_FADER)) ? COMMIT : SCAN;
      end
      COMMIT: state_d = IDLE;
      CLEAR: if (cnt_last) begin
        wp_clr    = 1'b1;
        overrun_d = 1'b0;
        state_d   = IDLE;
      end
      DUMP: state_d = cnt_last ? IDLE : DUMP;
      default: state_d = IDLE;
    endcase
    if (mem_clr && (state_q == SCAN || state_q == WAIT)) begin
      cnt_clr = 1'b1;
      state_d = CLEAR;
    end
  end
  always_ff @(posedge tb_clk) begin
    if (!tb_n_rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      mode_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mode_q    <= mode_d;
      overrun_q <= overrun_d;
    end
  end
endmodule

// File: tb/tb_daf_sequencer.sv
// tb_daf_sequencer: randomized scoreboard bench for daf_sequencer with a frame-timing reference model
module tb_daf_sequencer;
  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;
  logic tb_clk = 0, tb_n_rst = 0, sample_valid = 0, mem_clr = 0, mem_init = 0, mem_dump = 0;
  logic [3:0] swch_mode_en = 0, stage_done = 0, stage_go;
  logic out_load, mem_we, mem_wzero, mem_re, busy, overrun;
  logic [AW-1:0] mem_addr, wr_ptr;
  typedef struct {
    int cyc;
    logic [3:0] go;
    logic ld, we, wz, re;
    logic [AW-1:0] addr;
  } ev_t;
  ev_t exp_q[$];
  int checks = 0, errors = 0, cyc = 0, wp = 0;
  int lat[4];
  bit ovr = 0, arm = 0;
  daf_sequencer #(.ADDR_W(AW)) dut (
    .tb_clk(tb_clk), .tb_n_rst(tb_n_rst), .sample_valid(sample_valid),
    .swch_mode_en(swch_mode_en), .stage_done(stage_done), .mem_clr(mem_clr),
    .mem_init(mem_init), .mem_dump(mem_dump), .stage_go(stage_go), .out_load(out_load),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wzero(mem_wzero), .mem_re(mem_re),
    .wr_ptr(wr_ptr), .busy(busy), .overrun(overrun)
  );
  always #5 tb_clk = ~tb_clk;
  always @(posedge tb_clk) cyc <= cyc + 1;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end
  always @(negedge tb_clk) begin
    if (arm && (stage_go != 4'b0 || out_load || mem_we || mem_re)) begin
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got cyc=%0d go=%b ld=%b we=%b wz=%b re=%b addr=%0d, required no event",
                 cyc, stage_go, out_load, mem_we, mem_wzero, mem_re, mem_addr);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.go !== stage_go || e.ld !== out_load || e.we !== mem_we ||
            e.wz !== mem_wzero || e.re !== mem_re || e.addr !== mem_addr) begin
          errors++;
          $display("FAIL event: got cyc=%0d go=%b ld=%b we=%b wz=%b re=%b addr=%0d, required cyc=%0d go=%b ld=%b we=%b wz=%b re=%b addr=%0d",
                   cyc, stage_go, out_load, mem_we, mem_wzero, mem_re, mem_addr,
                   e.cyc, e.go, e.ld, e.we, e.wz, e.re, e.addr);
        end
      end
    end
  end
  function automatic void push(int c, logic [3:0] g, logic ld, logic we, logic wz, logic re, int a);
    ev_t e;
    e.cyc = c;
    e.go = g;
    e.ld = ld;
    e.we = we;
    e.wz = wz;
    e.re = re;
    e.addr = AW'(a);
    exp_q.push_back(e);
  endfunction
  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask
  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", n, act, exp);
    end
  endtask
  task automatic chk_idle(string tag);
    chk({tag, "_stage_go"}, stage_go, 0);
    chk({tag, "_out_load"}, out_load, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_wzero"}, mem_wzero, 0);
    chk({tag, "_mem_re"}, mem_re, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_wr_ptr"}, wr_ptr, 0);
  endtask
  // Model: stages run in order; an enabled stage costs 1 + done latency, a bypassed one costs 1.
  task automatic frame(input logic [3:0] m, input bit rnd);
    int t0 = cyc;
    int t = cyc + 1;
    int go_at[4];
    int dn_at[4];
    for (int i = 0; i < 4; i++) begin
      go_at[i] = -10;
      dn_at[i] = -10;
      if (m[i]) begin
        push(t, 4'(1 << i), 0, 0, 0, 0, wp);
        go_at[i] = t;
        dn_at[i] = t + lat[i];
        t += 1 + lat[i];
      end else t++;
    end
    push(t, 4'b0, 1, 1, 0, 0, wp);
    wp = (wp + 1) % DEPTH;
    sample_valid = 1;
    swch_mode_en = m;
    step();
    sample_valid = 0;
    for (int c = t0 + 1; c <= t; c++) begin
      logic [3:0] d;
      d = rnd ? 4'($urandom) : 4'h0;
      for (int i = 0; i < 4; i++) begin
        if (c > go_at[i] && c < dn_at[i]) d[i] = 1'b0;
        if (c == dn_at[i]) d[i] = 1'b1;
      end
      stage_done = d;
      if (rnd) begin
        swch_mode_en = 4'($urandom);
        sample_valid = ($urandom_range(0, 7) == 0);
        mem_init = ($urandom_range(0, 7) == 0);
        mem_dump = ($urandom_range(0, 7) == 0);
        if (sample_valid) ovr = 1;
      end
      step();
    end
    stage_done = 0;
    sample_valid = 0;
    mem_init = 0;
    mem_dump = 0;
    chk("busy_after_frame", busy, 0);
    chk("wr_ptr_after_frame", wr_ptr, wp);
    chk("overrun_after_frame", overrun, ovr);
  endtask
  task automatic clear_run(input bit with_dump);
    int c0 = cyc;
    for (int i = 0; i < DEPTH; i++) push(c0 + 1 + i, 4'b0, 0, 1, 1, 0, i);
    mem_clr = 1;
    mem_dump = with_dump;
    step();
    mem_clr = 0;
    mem_dump = 0;
    repeat (7) step();
    mem_clr = 1;
    step();
    mem_clr = 0;
    repeat (DEPTH - 9) step();
    chk("busy_last_clear", busy, 1);
    step();
    wp = 0;
    ovr = 0;
    chk("busy_after_clear", busy, 0);
    chk("wr_ptr_after_clear", wr_ptr, 0);
    chk("overrun_after_clear", overrun, 0);
  endtask
  task automatic dump_run();
    int c0 = cyc;
    for (int i = 0; i < DEPTH; i++) push(c0 + 1 + i, 4'b0, 0, 0, 0, 1, i);
    mem_dump = 1;
    step();
    mem_dump = 0;
    repeat (DEPTH - 1) step();
    chk("busy_last_dump", busy, 1);
    step();
    chk("busy_after_dump", busy, 0);
    chk("wr_ptr_after_dump", wr_ptr, wp);
  endtask
  initial begin
    int t0;
    repeat (3) step();
    chk_idle("reset");
    arm = 1;
    tb_n_rst = 1;
    step();
    lat = '{1, 1, 1, 1};
    frame(4'b0000, 0);
    frame(4'b1111, 0);
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++) lat[i] = $urandom_range(1, 4);
      frame(4'($urandom), 1);
      repeat ($urandom_range(0, 3)) step();
      if ($urandom_range(0, 5) == 0) begin
        mem_init = 1;
        step();
        mem_init = 0;
        wp = 0;
        chk("wr_ptr_after_init", wr_ptr, 0);
      end
    end
    dump_run();
    t0 = cyc;
    push(t0 + 1, 4'b0001, 0, 0, 0, 0, wp);
    sample_valid = 1;
    swch_mode_en = 4'b0101;
    step();
    sample_valid = 0;
    repeat (8) step();
    chk("busy_stalled", busy, 1);
    sample_valid = 1;
    step();
    sample_valid = 0;
    ovr = 1;
    chk("overrun_set", overrun, 1);
    clear_run(0);
    for (int i = 0; i < 3; i++) begin
      lat = '{2, 1, 3, 1};
      frame(4'b1010, 0);
    end
    clear_run(1);
    dump_run();
    t0 = cyc;
    push(t0 + 1, 4'b0001, 0, 0, 0, 0, wp);
    sample_valid = 1;
    swch_mode_en = 4'hF;
    step();
    sample_valid = 0;
    step();
    sample_valid = 1;
    step();
    sample_valid = 0;
    tb_n_rst = 0;
    step();
    tb_n_rst = 1;
    wp = 0;
    ovr = 0;
    chk_idle("mid_wait_reset");
    repeat (5) step();
    lat = '{1, 2, 1, 2};
    frame(4'b1111, 1);
    repeat (3) step();
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
